// File: rtl/multiplier_controller.sv
// Sequencing controller for an N-step shift/add multiplier datapath.
// Moore FSM: IDLE -> INIT -> SHIFT (N cycles) -> DONE, with abort and step count.
module multiplier_controller #(
  parameter  int unsigned N  = 4,
  localparam int unsigned SW = $clog2(N + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          result_ack,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic          do_init,
  output logic          do_shift,
  output logic [SW-1:0] step
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INIT  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [SW-1:0] STEP_LAST = SW'(N - 1);
  localparam logic [SW-1:0] STEP_MAX  = SW'(N);

  state_e        state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          do_init_q, do_init_d;
  logic          do_shift_q, do_shift_d;

  // Next state, step counter, and output decode of the next state so the
  // registered outputs always reflect the state they are paired with.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    ready_d    = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    do_init_d  = 1'b0;
    do_shift_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INIT;
      end
      S_INIT: begin
        step_d  = '0;
        state_d = abort ? S_IDLE : S_SHIFT;
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
          step_d  = '0;
        end else if (step_q >= STEP_LAST) begin
          // Saturate at N so step can never wrap even from a corrupted count.
          state_d = S_DONE;
          step_d  = STEP_MAX;
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      S_DONE: begin
        if (result_ack) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_IDLE:  ready_d = 1'b1;
      S_INIT:  begin do_init_d  = 1'b1; busy_d = 1'b1; end
      S_SHIFT: begin do_shift_d = 1'b1; busy_d = 1'b1; end
      S_DONE:  done_d = 1'b1;
      default: ready_d = 1'b1;
    endcase
  end

  // State and output registers; reset dominates every other input.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      do_init_q  <= 1'b0;
      do_shift_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      do_init_q  <= do_init_d;
      do_shift_q <= do_shift_d;
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign do_init  = do_init_q;
  assign do_shift = do_shift_q;
  assign step     = step_q;

endmodule

// File: tb/tb_multiplier_controller.sv
// Bench for multiplier_controller driving a small shift/add datapath model;
// expected products are queued at start acceptance and compared at done.
module tb_multiplier_controller;

  localparam int unsigned N  = 4;
  localparam int unsigned SW = $clog2(N + 1);
  localparam int unsigned PW = 2 * N;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          result_ack = 1'b0;
  logic          ready, busy, done, do_init, do_shift;
  logic [SW-1:0] step;

  logic [N-1:0]  a = '0;
  logic [N-1:0]  b = '0;
  logic [2*N:0]  p_q = '0;
  logic [N:0]    sum_c;
  logic [PW-1:0] product;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] exp_p;

  int checks = 0;
  int errors = 0;

  int cycles, inits, shifts;
  bit timeout;

  multiplier_controller #(.N(N)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .result_ack (result_ack),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .do_init    (do_init),
    .do_shift   (do_shift),
    .step       (step)
  );

  always #5 clock = ~clock;

  // Datapath model: {acc, multiplier} shifted right, multiplicand added on lsb.
  always_comb sum_c = p_q[2*N:N] + (p_q[0] ? {1'b0, a} : '0);

  always_ff @(posedge clock) begin
    if (do_init)       p_q <= {(N+1)'(0), b};
    else if (do_shift) p_q <= {1'b0, sum_c, p_q[N-1:1]};
  end

  assign product = p_q[PW-1:0];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_op(input logic [N-1:0] ma, input logic [N-1:0] mb);
    a = ma;
    b = mb;
    exp_q.push_back(PW'(int'(ma) * int'(mb)));
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    cycles = 0; inits = 0; shifts = 0; timeout = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        timeout = 1'b0;
        break;
      end
      inits  += int'(do_init);
      shifts += int'(do_shift);
      tick();
      cycles++;
    end
  endtask

  task automatic wait_step(input logic [SW-1:0] target);
    timeout = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (do_shift && step == target) begin
        timeout = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; a = 4'd3; b = 4'd2;
    tick(); tick();
    checks++; if (ready !== 1'b1)    begin errors++; $display("FAIL reset_ready got %b expected 1", ready); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got %b expected 0", done); end
    checks++; if (do_init !== 1'b0)  begin errors++; $display("FAIL reset_do_init got %b expected 0", do_init); end
    checks++; if (do_shift !== 1'b0) begin errors++; $display("FAIL reset_do_shift got %b expected 0", do_shift); end
    checks++; if (step !== SW'(0))   begin errors++; $display("FAIL reset_step got %0d expected 0", step); end
    reset = 1'b0;
    tick();
    checks++; if (do_init !== 1'b1 || busy !== 1'b1 || ready !== 1'b0)
      begin errors++; $display("FAIL reset_release_accept got init=%b busy=%b ready=%b expected 1 1 0", do_init, busy, ready); end
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (ready !== 1'b1 || step !== SW'(0) || do_shift !== 1'b0)
      begin errors++; $display("FAIL abort_in_init got ready=%b step=%0d shift=%b expected 1 0 0", ready, step, do_shift); end
  endtask

  task automatic test_basic();
    start_op(4'd11, 4'd6);
    wait_done();
    exp_p = exp_q.pop_front();
    checks++; if (timeout) begin errors++; $display("FAIL basic_timeout got no done expected done"); end
    checks++; if (inits !== 1)         begin errors++; $display("FAIL basic_init_cycles got %0d expected 1", inits); end
    checks++; if (shifts !== N)        begin errors++; $display("FAIL basic_shift_cycles got %0d expected %0d", shifts, N); end
    checks++; if (cycles !== N + 1)    begin errors++; $display("FAIL basic_latency got %0d expected %0d", cycles, N + 1); end
    checks++; if (product !== exp_p)   begin errors++; $display("FAIL basic_product got %0d expected %0d", product, exp_p); end
    checks++; if (exp_p !== PW'(66))   begin errors++; $display("FAIL basic_expected got %0d expected 66", exp_p); end
    checks++; if (step !== SW'(N))     begin errors++; $display("FAIL basic_step got %0d expected %0d", step, N); end
    tick(); tick();
    checks++; if (done !== 1'b1 || ready !== 1'b0)
      begin errors++; $display("FAIL basic_done_hold got done=%b ready=%b expected 1 0", done, ready); end
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    checks++; if (ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL basic_ack got ready=%b done=%b busy=%b expected 1 0 0", ready, done, busy); end
    checks++; if (step !== SW'(N)) begin errors++; $display("FAIL idle_step_hold got %0d expected %0d", step, N); end
    tick();
  endtask

  task automatic test_back_to_back();
    start_op(4'd11, 4'd6);
    wait_done();
    exp_p = exp_q.pop_front();
    checks++; if (timeout || product !== exp_p)
      begin errors++; $display("FAIL b2b_first got %0d expected %0d", product, exp_p); end
    a = 4'd15; b = 4'd15; start = 1'b1;
    tick(); tick();
    checks++; if (done !== 1'b1 || do_init !== 1'b0)
      begin errors++; $display("FAIL b2b_start_in_done got done=%b init=%b expected 1 0", done, do_init); end
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    checks++; if (ready !== 1'b1 || do_init !== 1'b0)
      begin errors++; $display("FAIL b2b_no_queue got ready=%b init=%b expected 1 0", ready, do_init); end
    exp_q.push_back(PW'(15 * 15));
    tick();
    start = 1'b0;
    checks++; if (do_init !== 1'b1) begin errors++; $display("FAIL b2b_accept got %b expected 1", do_init); end
    wait_done();
    exp_p = exp_q.pop_front();
    checks++; if (timeout || product !== exp_p || exp_p !== PW'(225))
      begin errors++; $display("FAIL b2b_second got %0d expected %0d", product, exp_p); end
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    int done_seen;
    start_op(4'd7, 4'd9);
    void'(exp_q.pop_back());
    wait_step(SW'(2));
    checks++; if (timeout) begin errors++; $display("FAIL abort_reach_step2 got no step 2 expected step 2"); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (ready !== 1'b1 || step !== SW'(0) || busy !== 1'b0 || do_shift !== 1'b0)
      begin errors++; $display("FAIL abort_shift got ready=%b step=%0d busy=%b shift=%b expected 1 0 0 0", ready, step, busy, do_shift); end
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      done_seen += int'(done);
      tick();
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL abort_no_done got %0d expected 0", done_seen); end
    start_op(4'd5, 4'd3);
    wait_done();
    exp_p = exp_q.pop_front();
    abort = 1'b1;
    tick();
    checks++; if (done !== 1'b1 || product !== exp_p)
      begin errors++; $display("FAIL abort_in_done got done=%b prod=%0d expected 1 %0d", done, product, exp_p); end
    result_ack = 1'b1;
    tick();
    abort = 1'b0; result_ack = 1'b0;
    checks++; if (ready !== 1'b1 || done !== 1'b0)
      begin errors++; $display("FAIL abort_ack_done got ready=%b done=%b expected 1 0", ready, done); end
    tick();
  endtask

  task automatic test_reset_mid_shift();
    start_op(4'd9, 4'd9);
    void'(exp_q.pop_back());
    wait_step(SW'(3));
    checks++; if (timeout) begin errors++; $display("FAIL rst_reach_step3 got no step 3 expected step 3"); end
    reset = 1'b1; abort = 1'b1; result_ack = 1'b1;
    tick();
    reset = 1'b0; abort = 1'b0; result_ack = 1'b0;
    checks++; if (ready !== 1'b1 || step !== SW'(0) || do_shift !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL rst_mid_shift got ready=%b step=%0d shift=%b busy=%b expected 1 0 0 0", ready, step, do_shift, busy); end
    tick();
  endtask

  task automatic test_hold_done();
    int bad;
    start_op(4'd13, 4'd5);
    wait_done();
    exp_p = exp_q.pop_front();
    checks++; if (timeout) begin errors++; $display("FAIL hold_timeout got no done expected done"); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      a = 4'(i);
      if (done !== 1'b1 || step !== SW'(N) || product !== exp_p || do_shift !== 1'b0) bad++;
      tick();
    end
    checks++; if (bad !== 0)
      begin errors++; $display("FAIL hold_done_stable got %0d bad cycles expected 0 (prod=%0d exp=%0d)", bad, product, exp_p); end
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL hold_ack got %b expected 1", ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_reset_mid_shift();
    test_hold_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
